// File: rtl/tagged_request_issuer_pkg.sv
// -----------------------------------------------------------------------------
// tagged_request_issuer_pkg
// Shared definitions for the tagged request issuer:
//   - default color count and payload width
//   - log2 helper used to size tag fields (bits needed to hold a value)
//   - FSM state encodings IDLE / BUSY / STREAM
// No ports (package).
// -----------------------------------------------------------------------------
package tagged_request_issuer_pkg;

    localparam int COLORS_DEFAULT     = 4;
    localparam int DATA_WIDTH_DEFAULT = 64;

    // IDLE   : output register empty
    // BUSY   : output beat held because downstream is not accepting
    // STREAM : output beat presented, back-to-back reload allowed
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_STREAM = 2'b10
    } issuer_state_e;

    // Number of bits needed to represent 'value' (at least one).
    // Used as log2(COLORS-1) to get the tag width.
    function automatic int log2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value;
        for (int i = 0; i < 31; i++) begin
            if (v > 0) begin
                bits = bits + 1;
                v    = v >>> 1;
            end else begin
                bits = bits;
            end
        end
        if (bits == 0) begin
            bits = 1;
        end else begin
            bits = bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/tagged_request_issuer_if.sv
// -----------------------------------------------------------------------------
// tagged_request_issuer_if
// Bundles the request-queue side, the tracker side and the issued-stream side
// of the tagged request issuer.
//   req_valid/req_data/req_ready : per-color request queues
//   ready_tag/ready              : tracker readiness query (ready is comb.)
//   push/push_tag                : tracker push for every issued request
//   out_valid/out_tag/out_data/out_ready : issued request stream
//   stat_tag/stat_issued/stat_skipped    : only with TAGGED_ISSUER_STATS_EN
// Modports: master = issuer, slave = its environment.
// -----------------------------------------------------------------------------
interface tagged_request_issuer_if
    import tagged_request_issuer_pkg::*;
#(
    parameter int COLORS     = COLORS_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    localparam int LOG2_COLORS = log2(COLORS - 1);

    logic [COLORS-1:0]            req_valid;
    logic [COLORS*DATA_WIDTH-1:0] req_data;
    logic [COLORS-1:0]            req_ready;
    logic [LOG2_COLORS-1:0]       ready_tag;
    logic                         ready;
    logic                         push;
    logic [LOG2_COLORS-1:0]       push_tag;
    logic                         out_valid;
    logic [LOG2_COLORS-1:0]       out_tag;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_ready;
`ifdef TAGGED_ISSUER_STATS_EN
    logic [LOG2_COLORS-1:0]       stat_tag;
    logic [31:0]                  stat_issued;
    logic [31:0]                  stat_skipped;
`endif

    modport master (
        input  req_valid, req_data, ready, out_ready,
        output req_ready, ready_tag, push, push_tag, out_valid, out_tag, out_data
`ifdef TAGGED_ISSUER_STATS_EN
        , input stat_tag
        , output stat_issued, stat_skipped
`endif
    );

    modport slave (
        output req_valid, req_data, ready, out_ready,
        input  req_ready, ready_tag, push, push_tag, out_valid, out_tag, out_data
`ifdef TAGGED_ISSUER_STATS_EN
        , output stat_tag
        , input stat_issued, stat_skipped
`endif
    );

endinterface

// File: rtl/tagged_request_issuer_rr_pick.sv
// -----------------------------------------------------------------------------
// tagged_request_issuer_rr_pick
// Combinational round-robin picker: first color with req_valid set, scanning
// upward from rr_ptr with wrap. When nothing is valid, cand = rr_ptr.
// Ports:
//   req_valid [COLORS]      in  per-color valid
//   rr_ptr    [LOG2_COLORS] in  scan start position
//   cand      [LOG2_COLORS] out selected color
//   any_valid                out at least one request valid
// COLORS must be a power of two so the tag arithmetic wraps by truncation.
// -----------------------------------------------------------------------------
module tagged_request_issuer_rr_pick #(
    parameter int COLORS      = 4,
    parameter int LOG2_COLORS = 2
) (
    input  logic [COLORS-1:0]      req_valid,
    input  logic [LOG2_COLORS-1:0] rr_ptr,
    output logic [LOG2_COLORS-1:0] cand,
    output logic                   any_valid
);

    logic [LOG2_COLORS-1:0] idx_s;

    // Scan from the farthest offset down to offset 0 so the nearest valid
    // color after rr_ptr is the last one written and therefore wins.
    always_comb begin
        cand  = rr_ptr;
        idx_s = rr_ptr;
        for (int k = COLORS - 1; k >= 0; k--) begin
            idx_s = rr_ptr + LOG2_COLORS'(k);
            cand  = req_valid[idx_s] ? idx_s : cand;
        end
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/tagged_request_issuer.sv
// -----------------------------------------------------------------------------
// tagged_request_issuer
// Initiator side of the in-flight tracking interface. Arbitrates COLORS tagged
// request queues into one output stream, gated per color by the tracker's
// ready, and pushes the tag of every issued request to the tracker.
// Ports:
//   clk    in  clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    tagged_request_issuer_if.master (request, tracker, output stream)
// Optional feature: define TAGGED_ISSUER_STATS_EN to add per-color ACCEPT and
// SKIP counters readable through stat_tag / stat_issued / stat_skipped with a
// one-cycle registered read.
// -----------------------------------------------------------------------------
module tagged_request_issuer
    import tagged_request_issuer_pkg::*;
#(
    parameter int COLORS      = COLORS_DEFAULT,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    localparam int LOG2_COLORS = log2(COLORS - 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tagged_request_issuer_if.master bus
);

    localparam logic [LOG2_COLORS-1:0] TAG_ONE  = LOG2_COLORS'(1'b1);
    localparam logic [LOG2_COLORS-1:0] TAG_ZERO = {LOG2_COLORS{1'b0}};

    issuer_state_e          state_r;
    issuer_state_e          state_nxt_s;
    logic [LOG2_COLORS-1:0] rr_ptr_r;
    logic [LOG2_COLORS-1:0] cand_s;
    logic                   any_valid_s;
    logic                   out_valid_s;
    logic                   slot_free_s;
    logic                   accept_s;
    logic                   skip_s;
    logic [COLORS-1:0]      req_ready_s;
    logic [LOG2_COLORS-1:0] ready_tag_s;
    logic [DATA_WIDTH-1:0]  cand_data_s;
    logic                   push_r;
    logic [LOG2_COLORS-1:0] push_tag_r;
    logic [LOG2_COLORS-1:0] out_tag_r;
    logic [DATA_WIDTH-1:0]  out_data_r;

    tagged_request_issuer_rr_pick #(
        .COLORS      (COLORS),
        .LOG2_COLORS (LOG2_COLORS)
    ) u_rr_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_r),
        .cand      (cand_s),
        .any_valid (any_valid_s)
    );

    assign cand_data_s = bus.req_data[int'(cand_s)*DATA_WIDTH +: DATA_WIDTH];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a held beat parks in BUSY; a reload keeps STREAM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY, ST_STREAM: begin
                if (!bus.out_ready) begin
                    state_nxt_s = ST_BUSY;
                end else if (accept_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: accept/skip decision, per-color strobe and tracker query.
    // A stalled output slot takes priority over a skip so rr_ptr is held.
    // req_ready and ready_tag are forced to zero while reset is asserted.
    always_comb begin
        out_valid_s = (state_r != ST_IDLE);
        slot_free_s = !out_valid_s || bus.out_ready;
        accept_s    = any_valid_s && bus.ready && slot_free_s;
        skip_s      = any_valid_s && !bus.ready && slot_free_s;
        req_ready_s = {COLORS{1'b0}};
        if (rst_n && accept_s) begin
            req_ready_s[cand_s] = 1'b1;
        end else begin
            req_ready_s = {COLORS{1'b0}};
        end
        if (rst_n) begin
            ready_tag_s = cand_s;
        end else begin
            ready_tag_s = TAG_ZERO;
        end
    end

    // Output register, push pulse and round-robin pointer.
    // push follows accept directly, so it is high only on the first cycle of
    // a beat: a held beat never has an accept behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_r     <= 1'b0;
            push_tag_r <= TAG_ZERO;
            out_tag_r  <= TAG_ZERO;
            out_data_r <= {DATA_WIDTH{1'b0}};
            rr_ptr_r   <= TAG_ZERO;
        end else begin
            push_r <= accept_s;
            if (accept_s) begin
                push_tag_r <= cand_s;
                out_tag_r  <= cand_s;
                out_data_r <= cand_data_s;
                rr_ptr_r   <= cand_s + TAG_ONE;
            end else if (skip_s) begin
                rr_ptr_r   <= cand_s + TAG_ONE;
            end else begin
                rr_ptr_r   <= rr_ptr_r;
            end
        end
    end

`ifdef TAGGED_ISSUER_STATS_EN
    logic [31:0] issued_cnt_r  [COLORS];
    logic [31:0] skipped_cnt_r [COLORS];
    logic [31:0] stat_issued_r;
    logic [31:0] stat_skipped_r;

    // Per-color ACCEPT / SKIP counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLORS; c++) begin
                issued_cnt_r[c]  <= 32'd0;
                skipped_cnt_r[c] <= 32'd0;
            end
        end else begin
            if (accept_s) begin
                issued_cnt_r[cand_s] <= issued_cnt_r[cand_s] + 32'd1;
            end else if (skip_s) begin
                skipped_cnt_r[cand_s] <= skipped_cnt_r[cand_s] + 32'd1;
            end else begin
                issued_cnt_r[cand_s] <= issued_cnt_r[cand_s];
            end
        end
    end

    // Registered statistics read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_r  <= 32'd0;
            stat_skipped_r <= 32'd0;
        end else begin
            stat_issued_r  <= issued_cnt_r[bus.stat_tag];
            stat_skipped_r <= skipped_cnt_r[bus.stat_tag];
        end
    end

    assign bus.stat_issued  = stat_issued_r;
    assign bus.stat_skipped = stat_skipped_r;
`endif

    assign bus.req_ready = req_ready_s;
    assign bus.ready_tag = ready_tag_s;
    assign bus.push      = push_r;
    assign bus.push_tag  = push_tag_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_tagged_request_issuer.sv
// -----------------------------------------------------------------------------
// tb_tagged_request_issuer
// Self-checking bench for tagged_request_issuer (COLORS=4, DATA_WIDTH=64).
// A transaction-level reference model (round-robin pointer as an integer,
// output beat as a few flags) predicts every output each cycle; directed
// sequences cover single issue, back-to-back streaming, tracker-not-ready
// skipping, downstream hold and mid-stream reset, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_tagged_request_issuer;

    localparam int C  = 4;
    localparam int DW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tagged_request_issuer_if #(.COLORS(C), .DATA_WIDTH(DW)) bus ();

    tagged_request_issuer #(.COLORS(C), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Tracker stand-in: per-color readiness looked up by the queried tag.
    logic [C-1:0] rdy_mask;
    always_comb bus.ready = rdy_mask[bus.ready_tag];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] dat [C];

    // Reference model state
    int            m_rr;
    bit            m_ov;
    bit            m_push;
    int            m_tag;
    int            m_ptag;
    logic [DW-1:0] m_data;
    int            m_iss [C];
    int            m_skp [C];

    int push_log [$];
    bit rr1_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_ov = 0; m_push = 0; m_tag = 0; m_ptag = 0; m_data = '0;
        for (int i = 0; i < C; i++) begin
            m_iss[i] = 0;
            m_skp[i] = 0;
        end
        push_log.delete();
    endtask

    task automatic randomize_data();
        for (int i = 0; i < C; i++) dat[i] = {$urandom, $urandom};
    endtask

    // One cycle: drive at posedge+1, check at posedge+2, advance model, wait edge.
    task automatic step(input logic [C-1:0] v, input bit ordy, input logic [C-1:0] mask);
        int cand;
        bit anyv, rdy, slot, acc, skp;
        logic [C-1:0] exp_rr;
        bus.req_valid = v;
        for (int i = 0; i < C; i++) bus.req_data[i*DW +: DW] = dat[i];
        bus.out_ready = ordy;
        rdy_mask      = mask;
        #1;
        anyv = (v != '0);
        cand = m_rr;
        if (anyv) begin
            for (int k = C - 1; k >= 0; k--) begin
                if (v[(m_rr + k) % C]) cand = (m_rr + k) % C;
            end
        end
        rdy  = mask[cand];
        slot = !m_ov || ordy;
        acc  = anyv && rdy && slot;
        skp  = anyv && !rdy && slot;
        exp_rr = '0;
        if (acc) exp_rr[cand] = 1'b1;

        check("ready_tag", bus.ready_tag, cand);
        check("req_ready", bus.req_ready, exp_rr);
        check("out_valid", bus.out_valid, m_ov);
        if (m_ov) begin
            check("out_tag", bus.out_tag, m_tag);
            check("out_data", bus.out_data, m_data);
        end
        check("push", bus.push, m_push);
        if (m_push) check("push_tag", bus.push_tag, m_ptag);
        if (bus.push) push_log.push_back(int'(bus.push_tag));
        if (bus.req_ready[1]) rr1_seen = 1'b1;

        if (acc) begin
            m_ov   = 1'b1;
            m_tag  = cand;
            m_data = dat[cand];
            m_push = 1'b1;
            m_ptag = cand;
            m_rr   = (cand + 1) % C;
            m_iss[cand]++;
        end else begin
            m_push = 1'b0;
            if (m_ov && ordy) m_ov = 1'b0;
            if (skp) begin
                m_rr = (cand + 1) % C;
                m_skp[cand]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        bus.req_valid = 4'b1110;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_push", bus.push, 1'b0);
        check("rst_push_tag", bus.push_tag, 2'd0);
        check("rst_out_tag", bus.out_tag, 2'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_ready_tag", bus.ready_tag, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int exp_t2 [6];
        int exp_t3 [6];
        exp_t2 = '{0, 1, 2, 3, 0, 1};
        exp_t3 = '{0, 2, 3, 0, 2, 3};
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        rdy_mask      = '0;
`ifdef TAGGED_ISSUER_STATS_EN
        bus.stat_tag  = 2'd0;
`endif
        for (int i = 0; i < C; i++) dat[i] = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single request on color 2
        randomize_data();
        dat[2] = 64'hAB;
        step(4'b0100, 1'b1, 4'hF);
        check("t1_out_valid", bus.out_valid, 1'b1);
        check("t1_out_tag", bus.out_tag, 2'd2);
        check("t1_out_data", bus.out_data, 64'hAB);
        check("t1_push", bus.push, 1'b1);
        check("t1_push_tag", bus.push_tag, 2'd2);
        step(4'b0000, 1'b1, 4'hF);
        step(4'b0000, 1'b1, 4'hF);

        // All valid, everything ready: back-to-back rotation
        do_reset();
        randomize_data();
        for (int i = 0; i < 7; i++) step(4'hF, 1'b1, 4'hF);
        check("t2_npush", push_log.size(), 6);
        for (int i = 0; i < 6 && i < push_log.size(); i++)
            check("t2_tag_seq", push_log[i], exp_t2[i]);

        // Tracker never ready for color 1
        do_reset();
        rr1_seen = 1'b0;
        randomize_data();
        for (int i = 0; i < 10; i++) step(4'hF, 1'b1, 4'b1101);
        check("t3_npush_ge6", push_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < push_log.size(); i++)
            check("t3_tag_seq", push_log[i], exp_t3[i]);
        check("t3_req_ready1_never", rr1_seen, 1'b0);

        // Downstream holds for 5 cycles, then releases
        randomize_data();
        step(4'hF, 1'b1, 4'hF);
        for (int i = 0; i < 5; i++) step(4'hF, 1'b0, 4'hF);
        step(4'hF, 1'b1, 4'hF);
        check("t4_push_after_release", bus.push, 1'b1);
        step(4'hF, 1'b1, 4'hF);

        // Reset mid-stream; first grant afterwards is color 0
        step(4'hF, 1'b1, 4'hF);
        do_reset();
        randomize_data();
        step(4'hF, 1'b1, 4'hF);
        check("t5_first_tag", bus.out_tag, 2'd0);
        step(4'h0, 1'b1, 4'hF);

`ifdef TAGGED_ISSUER_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 4'hF);
        for (int i = 0; i < 2; i++) step(4'b0010, 1'b1, 4'b1101);
        step(4'b0000, 1'b1, 4'hF);
        bus.stat_tag = 2'd0;
        @(posedge clk);
        #1;
        check("t6_issued0", bus.stat_issued, 32'd3);
        bus.stat_tag = 2'd1;
        @(posedge clk);
        #1;
        check("t6_skipped1", bus.stat_skipped, 32'd2);
        do_reset();
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            randomize_data();
            step(C'($urandom), ($urandom_range(0, 3) != 0), C'($urandom));
        end

`ifdef TAGGED_ISSUER_STATS_EN
        bus.req_valid = '0;
        for (int c = 0; c < C; c++) begin
            bus.stat_tag = 2'(c);
            @(posedge clk);
            #1;
            check("rand_issued", bus.stat_issued, 32'(m_iss[c]));
            check("rand_skipped", bus.stat_skipped, 32'(m_skp[c]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
